pwm_gen_core: RTL and testbench
===============================

# pwm_gen_core

PWM generator core that sits directly downstream of the AXI4-Lite slave register file of the PWM IP. It consumes the control, period, duty and dead-time register values and produces a glitch-free PWM waveform, with period/duty updates applied only at period boundaries. It also emits per-period tick and update-acknowledge pulses, and exposes a live counter value for status readback.

## Interface
- C_CNT_WIDTH, 16, width of period/duty/counter.
- C_DT_WIDTH, 8, width of dead-time count.

- ACLK  in  1  clock.
- ARESETN  in  1  reset; asynchronous assert, active-low.
- cfg_enable  in  1  run enable (slv_reg0[0]).
- cfg_polarity  in  1  output polarity; 1 inverts both outputs (slv_reg0[1]).
- cfg_period  in  C_CNT_WIDTH  period minus one (slv_reg1).
- cfg_duty  in  C_CNT_WIDTH  active cycles per period (slv_reg2).
- cfg_deadtime  in  C_DT_WIDTH  dead-time cycles (slv_reg3[7:0]); used only with PWM_DEADTIME_EN.
- cfg_update  in  1  one-cycle pulse from the register file on any write to slv_reg1..3.
- pwm_out  out  1  PWM output.
- pwm_out_n  out  1  complementary PWM output.
- period_tick  out  1  one-cycle pulse on counter wrap.
- update_ack  out  1  one-cycle pulse when shadow registers load from pending.
- cnt_value  out  C_CNT_WIDTH  current counter.

## Operation
- Reset values: cnt 0, state IDLE, shadows 0, pending 0, pwm_out 0, pwm_out_n 0, period_tick 0, update_ack 0.
- State IDLE:
  - cnt held at 0.
  - pwm_out and pwm_out_n both at the inactive level, which equals cfg_polarity.
  - cfg_enable sampled high → load period/duty/deadtime shadows directly from cfg_*, clear pending, cnt 0, go to RUN.
- State RUN:
  - cnt increments each cycle.
  - At cnt == period_sh: cnt wraps to 0 and period_tick pulses.
  - If pending is set at the wrap, shadows reload from cfg_*, pending clears, and update_ack pulses in the same cycle as period_tick.
- Period is period_sh+1 cycles. period_sh = 0 gives cnt fixed at 0 and period_tick every cycle.
- Raw output = (cnt < duty_sh), unsigned compare.
  - duty_sh = 0 gives constant inactive.
  - duty_sh > period_sh gives constant active, with no gap at the wrap.
- pwm_out = raw ^ cfg_polarity.
- cfg_update sets pending.
  - cfg_update coinciding with a wrap loads the current cfg_* values at that wrap; no stale pending remains.
  - cfg_update while IDLE is absorbed by the load on enable.
- cfg_enable sampled low in RUN → IDLE next edge. Outputs go inactive, cnt goes to 0, pending clears. There is no wait for period end.
- ARESETN low at any time clears all state immediately, including mid-period.

## Timing
- All outputs are registered.
- Latency: pwm_out(t+1) reflects cnt(t). The first active cycle is the cycle after entering RUN.
- With cfg_period=P and cfg_duty=D (D ≤ P), pwm_out is active for exactly D of every P+1 cycles.
- cnt_value is the cnt register with no extra delay.
- cfg_* are quasi-static registers in the same clock domain; no synchronisers are required.

## Configuration
- Macro: PWM_DEADTIME_EN.
- Defined:
  - pwm_out_n is the active-high complement of raw.
  - On every raw transition, a dead-time counter loads deadtime_sh. Both outputs are held inactive for exactly deadtime_sh cycles, then the new side drives active.
  - An active phase shorter than deadtime_sh never asserts its output.
  - pwm_out and pwm_out_n are never simultaneously active.
  - deadtime_sh = 0 is identical to the undefined behaviour.
- Undefined:
  - In RUN, pwm_out_n = ~raw ^ cfg_polarity; in IDLE it is inactive.
  - There is no dead-time counter, and cfg_deadtime is ignored.

## Test plan
- Reset: hold ARESETN low with cfg_enable=1 → pwm_out=0, pwm_out_n=0, cnt_value=0, no ticks. Release → RUN entered; first pwm_out active on the following cycle.
- cfg_period=9, cfg_duty=3, cfg_polarity=0, enable → pwm_out high 3 and low 7 cycles, repeating; period_tick every 10 cycles, coinciding with cnt_value=9.
- Duty boundaries with period 9:
  - cfg_duty=0 → pwm_out constantly 0.
  - cfg_duty=10 → constantly 1 across wraps.
  - cfg_polarity=1 inverts both results.
- Update timing: with period 9, duty 3, write duty 7 and pulse cfg_update at cnt_value=4 → the current period stays 3 high. update_ack and period_tick pulse together at the wrap. The next period is 7 high.
- Abort: drop cfg_enable while pwm_out=1 → pwm_out=0 and cnt_value=0 next cycle. Re-enable → a fresh period starts from cnt 0.
- PWM_DEADTIME_EN, period 9, duty 5, deadtime 2 → pwm_out high 3, gap 2, pwm_out_n high 3, gap 2, repeating; never both high. With deadtime 6, pwm_out never asserts.

Source files
------------

// File: rtl/pwm_gen_core.sv
// PWM generator core: shadowed period/duty applied at period boundaries, registered outputs, tick/ack pulses.
// Latency: outputs reflect the counter one cycle later. No backpressure. Optional dead-time insertion under PWM_DEADTIME_EN.
module pwm_gen_core #(
    parameter int C_CNT_WIDTH = 16,
    parameter int C_DT_WIDTH  = 8
) (
    input  logic                   ACLK,
    input  logic                   ARESETN,
    input  logic                   cfg_enable,
    input  logic                   cfg_polarity,
    input  logic [C_CNT_WIDTH-1:0] cfg_period,
    input  logic [C_CNT_WIDTH-1:0] cfg_duty,
    input  logic [C_DT_WIDTH-1:0]  cfg_deadtime,
    input  logic                   cfg_update,
    output logic                   pwm_out,
    output logic                   pwm_out_n,
    output logic                   period_tick,
    output logic                   update_ack,
    output logic [C_CNT_WIDTH-1:0] cnt_value
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]             state_q, state_d;
    logic [C_CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [C_CNT_WIDTH-1:0] period_sh_q, period_sh_d;
    logic [C_CNT_WIDTH-1:0] duty_sh_q, duty_sh_d;
    logic                   pending_q, pending_d;
    logic                   pwm_q, pwm_d;
    logic                   pwm_n_q, pwm_n_d;
    logic                   tick_q, tick_d;
    logic                   ack_q, ack_d;
    logic                   raw;
    logic                   run_ok;
    logic                   load;

`ifdef PWM_DEADTIME_EN
    logic [C_DT_WIDTH-1:0]  dt_sh_q, dt_sh_d;
    logic [C_DT_WIDTH-1:0]  dt_cnt_q, dt_cnt_d;
    logic                   raw_prev_q, raw_prev_d;
    logic                   trans;
    logic                   blk;
`else
    logic                   dt_unused;
    assign dt_unused = ^cfg_deadtime;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        period_sh_d = period_sh_q;
        duty_sh_d   = duty_sh_q;
        pending_d   = pending_q;
        load        = 1'b0;
        raw         = (cnt_q < duty_sh_q);
        // output path only drives active while staying in RUN this edge
        run_ok      = (state_q == ST_RUN) && cfg_enable;

        if (state_q == ST_IDLE) begin
            cnt_d     = '0;
            pending_d = 1'b0;
            if (cfg_enable) begin
                state_d = ST_RUN;
                load    = 1'b1;
            end
        end else if (!cfg_enable) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            pending_d = 1'b0;
        end else if (cnt_q == period_sh_q) begin
            cnt_d     = '0;
            load      = pending_q | cfg_update;
            pending_d = 1'b0;
        end else begin
            cnt_d     = cnt_q + 1'b1;
            pending_d = pending_q | cfg_update;
        end

        if (load) begin
            period_sh_d = cfg_period;
            duty_sh_d   = cfg_duty;
        end

        // tick/ack are predicted one cycle early so they coincide with cnt == period_sh
        tick_d = (state_d == ST_RUN) && (cnt_d == period_sh_d);
        ack_d  = tick_d && pending_d;

`ifdef PWM_DEADTIME_EN
        dt_sh_d    = load ? cfg_deadtime : dt_sh_q;
        trans      = run_ok && (raw != raw_prev_q);
        blk        = trans ? (dt_sh_q != '0) : (dt_cnt_q != '0);
        raw_prev_d = run_ok ? raw : 1'b0;
        if (!run_ok) begin
            dt_cnt_d = '0;
        end else if (trans) begin
            dt_cnt_d = (dt_sh_q == '0) ? '0 : dt_sh_q - 1'b1;
        end else if (dt_cnt_q != '0) begin
            dt_cnt_d = dt_cnt_q - 1'b1;
        end else begin
            dt_cnt_d = '0;
        end
        pwm_d   = run_ok ? ((raw & ~blk) ^ cfg_polarity) : cfg_polarity;
        pwm_n_d = run_ok ? ((~raw & ~blk) ^ cfg_polarity) : cfg_polarity;
`else
        pwm_d   = run_ok ? (raw ^ cfg_polarity) : cfg_polarity;
        pwm_n_d = run_ok ? (~raw ^ cfg_polarity) : cfg_polarity;
`endif
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            period_sh_q <= '0;
            duty_sh_q   <= '0;
            pending_q   <= 1'b0;
            pwm_q       <= 1'b0;
            pwm_n_q     <= 1'b0;
            tick_q      <= 1'b0;
            ack_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            period_sh_q <= period_sh_d;
            duty_sh_q   <= duty_sh_d;
            pending_q   <= pending_d;
            pwm_q       <= pwm_d;
            pwm_n_q     <= pwm_n_d;
            tick_q      <= tick_d;
            ack_q       <= ack_d;
        end
    end

`ifdef PWM_DEADTIME_EN
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            dt_sh_q    <= '0;
            dt_cnt_q   <= '0;
            raw_prev_q <= 1'b0;
        end else begin
            dt_sh_q    <= dt_sh_d;
            dt_cnt_q   <= dt_cnt_d;
            raw_prev_q <= raw_prev_d;
        end
    end
`endif

    assign pwm_out     = pwm_q;
    assign pwm_out_n   = pwm_n_q;
    assign period_tick = tick_q;
    assign update_ack  = ack_q;
    assign cnt_value   = cnt_q;

endmodule

// File: tb/tb_pwm_gen_core.sv
// Bench for pwm_gen_core: vector table, directed corner sequences and random stimulus against a cycle reference model.
`timescale 1ns/1ps
module tb_pwm_gen_core;
    localparam int W  = 16;
    localparam int DW = 8;

    logic          ACLK = 1'b0;
    logic          ARESETN = 1'b0;
    logic          cfg_enable = 1'b0;
    logic          cfg_polarity = 1'b0;
    logic [W-1:0]  cfg_period = '0;
    logic [W-1:0]  cfg_duty = '0;
    logic [DW-1:0] cfg_deadtime = '0;
    logic          cfg_update = 1'b0;
    logic          pwm_out, pwm_out_n, period_tick, update_ack;
    logic [W-1:0]  cnt_value;

    pwm_gen_core #(.C_CNT_WIDTH(W), .C_DT_WIDTH(DW)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .cfg_enable(cfg_enable), .cfg_polarity(cfg_polarity),
        .cfg_period(cfg_period), .cfg_duty(cfg_duty),
        .cfg_deadtime(cfg_deadtime), .cfg_update(cfg_update),
        .pwm_out(pwm_out), .pwm_out_n(pwm_out_n),
        .period_tick(period_tick), .update_ack(update_ack),
        .cnt_value(cnt_value)
    );

    always #5 ACLK = ~ACLK;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: one raw sample per RUN cycle, with the dead-time in force when it was taken
    typedef struct { bit raw; int dt; } samp_t;
    samp_t hist[$];
    bit    hist_base;
    bit    m_run, m_pend;
    int    m_cnt, m_per, m_duty, m_dt;
    bit    e_out, e_outn, e_tick, e_ack;

    task automatic model_load();
        m_per  = int'(cfg_period);
        m_duty = int'(cfg_duty);
`ifdef PWM_DEADTIME_EN
        m_dt   = int'(cfg_deadtime);
`else
        m_dt   = 0;
`endif
    endtask

    task automatic model_edge();
        bit raw, blk, prev;
        int n;
        samp_t s;
        if (!ARESETN) begin
            m_run = 0; m_pend = 0; m_cnt = 0; m_per = 0; m_duty = 0; m_dt = 0;
            e_out = 0; e_outn = 0; e_tick = 0; e_ack = 0;
            hist.delete(); hist_base = 0;
            return;
        end
        raw = m_run && (m_cnt < m_duty);
        if (m_run && cfg_enable) begin
            s.raw = raw; s.dt = m_dt;
            hist.push_back(s);
            if (hist.size() > 300) begin
                hist_base = hist[0].raw;
                void'(hist.pop_front());
            end
            n = hist.size();
            blk = 0;
            for (int i = 0; i < n; i++) begin
                prev = (i == 0) ? hist_base : hist[i-1].raw;
                if (hist[i].raw != prev && (n - 1 - i) < hist[i].dt) blk = 1;
            end
            e_out  = (raw && !blk) ^ cfg_polarity;
            e_outn = (!raw && !blk) ^ cfg_polarity;
        end else begin
            hist.delete(); hist_base = 0;
            e_out = cfg_polarity; e_outn = cfg_polarity;
        end
        if (!m_run) begin
            m_cnt = 0; m_pend = 0;
            if (cfg_enable) begin m_run = 1; model_load(); end
        end else if (!cfg_enable) begin
            m_run = 0; m_cnt = 0; m_pend = 0;
        end else if (m_cnt == m_per) begin
            m_cnt = 0;
            if (m_pend || cfg_update) model_load();
            m_pend = 0;
        end else begin
            m_cnt++;
            if (cfg_update) m_pend = 1;
        end
        e_tick = m_run && (m_cnt == m_per);
        e_ack  = e_tick && m_pend;
    endtask

    task automatic step();
        @(posedge ACLK);
        model_edge();
        #1;
        chk("pwm_out", pwm_out, e_out);
        chk("pwm_out_n", pwm_out_n, e_outn);
        chk("period_tick", period_tick, e_tick);
        chk("update_ack", update_ack, e_ack);
        chk("cnt_value", cnt_value, m_cnt);
    endtask

    typedef struct { int per; int duty; bit pol; int exp_high; int exp_ticks; } vec_t;
    vec_t tbl[10];

    initial begin
        int hi, hn, both, tk, r;

        tbl[0] = '{9, 3, 1'b0, 6, 2};
        tbl[1] = '{9, 0, 1'b0, 0, 2};
        tbl[2] = '{9, 10, 1'b0, 20, 2};
        tbl[3] = '{9, 3, 1'b1, 14, 2};
        tbl[4] = '{9, 0, 1'b1, 20, 2};
        tbl[5] = '{9, 10, 1'b1, 0, 2};
        tbl[6] = '{0, 0, 1'b0, 0, 2};
        tbl[7] = '{0, 1, 1'b0, 2, 2};
        tbl[8] = '{4, 2, 1'b0, 4, 2};
        tbl[9] = '{4, 4, 1'b1, 2, 2};

        // reset held with enable high
        ARESETN = 0; cfg_enable = 1; cfg_period = 9; cfg_duty = 3;
        repeat (3) step();
        chk("rst_pwm", pwm_out, 0);
        chk("rst_pwm_n", pwm_out_n, 0);
        chk("rst_cnt", cnt_value, 0);
        chk("rst_tick", period_tick, 0);
        ARESETN = 1;
        step();
        chk("entry_cnt", cnt_value, 0);
        chk("entry_pwm", pwm_out, 0);
        step();
        chk("first_active", pwm_out, 1);

        foreach (tbl[k]) begin
            cfg_enable = 0;
            step(); step();
            cfg_period = tbl[k].per; cfg_duty = tbl[k].duty; cfg_polarity = tbl[k].pol;
            cfg_enable = 1;
            step();
            hi = 0; tk = 0;
            repeat (2 * (tbl[k].per + 1)) begin
                step();
                hi += int'(pwm_out);
                if (period_tick) begin
                    tk++;
                    chk("tick_at_period_end", cnt_value, tbl[k].per);
                end
            end
            chk("vec_high_count", hi, tbl[k].exp_high);
            chk("vec_tick_count", tk, tbl[k].exp_ticks);
        end

        // update lands only at the wrap
        cfg_enable = 0; cfg_polarity = 0; step(); step();
        cfg_period = 9; cfg_duty = 3; cfg_enable = 1;
        step();
        for (int i = 0; i < 40 && cnt_value != 4; i++) step();
        chk("reach_cnt4", cnt_value, 4);
        cfg_duty = 7; cfg_update = 1;
        step();
        cfg_update = 0;
        hi = int'(pwm_out);
        for (int i = 0; i < 20 && !period_tick; i++) begin
            step();
            hi += int'(pwm_out);
        end
        chk("upd_tick", period_tick, 1);
        chk("upd_ack_with_tick", update_ack, 1);
        chk("upd_old_period_tail", hi, 0);
        hi = 0;
        repeat (10) begin step(); hi += int'(pwm_out); end
        chk("upd_new_period_high", hi, 7);
        chk("upd_next_tick", period_tick, 1);
        chk("upd_no_second_ack", update_ack, 0);

        // abort mid active phase
        for (int i = 0; i < 20 && !pwm_out; i++) step();
        chk("reach_active", pwm_out, 1);
        cfg_enable = 0;
        step();
        chk("abort_pwm", pwm_out, 0);
        chk("abort_cnt", cnt_value, 0);
        cfg_enable = 1;
        step();
        chk("reenter_cnt", cnt_value, 0);
        step();
        chk("reenter_cnt1", cnt_value, 1);
        chk("reenter_pwm", pwm_out, 1);

`ifdef PWM_DEADTIME_EN
        for (int d = 0; d < 2; d++) begin
            cfg_enable = 0; step(); step();
            cfg_period = 9; cfg_duty = 5; cfg_deadtime = (d == 0) ? 8'd2 : 8'd6;
            cfg_enable = 1;
            step();
            hi = 0; hn = 0; both = 0;
            repeat (20) begin
                step();
                hi += int'(pwm_out); hn += int'(pwm_out_n);
                both += int'(pwm_out & pwm_out_n);
            end
            chk("dt_high", hi, (d == 0) ? 6 : 0);
            chk("dt_high_n", hn, (d == 0) ? 6 : 0);
            chk("dt_overlap", both, 0);
        end
`endif

        cfg_enable = 1; cfg_deadtime = 0;
        for (int c = 0; c < 1500; c++) begin
            cfg_update = 0;
            r = $urandom_range(0, 99);
            if (r < 5) begin cfg_period = W'($urandom_range(0, 12)); cfg_update = 1; end
            else if (r < 10) begin cfg_duty = W'($urandom_range(0, 14)); cfg_update = 1; end
            else if (r < 12) begin cfg_deadtime = DW'($urandom_range(0, 7)); cfg_update = 1; end
            else if (r < 14) cfg_enable = ~cfg_enable;
            else if (r < 15) cfg_polarity = ~cfg_polarity;
            else if (r < 18) cfg_update = 1;
            else if (r < 20) cfg_duty = W'($urandom_range(0, 14));
            if (c == 700) ARESETN = 0;
            if (c == 703) ARESETN = 1;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
